p1_position_integrator: RTL and testbench

- Owns player 1's horizontal position register. Once per video frame it sums walk velocity or knockback motion into Xpos.
- Clamps the result to the stage walls and to the opponent pushbox, and computes facing (RyuLeft).
- Sits directly downstream of the player-1 knockback controller: consumes its per-frame Ball_X_Motion and feeds Xpos back to it.

---
 rtl/game_pkg.sv | 18 +
 rtl/p1_walk_fsm.sv | 47 ++++
 rtl/p1_position_integrator.sv | 68 ++++++
 tb/tb_p1_position_integrator.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: stage geometry, walk tuning and walk-state encoding shared by player logic
package game_pkg;
  localparam int SCREEN_W = 640;
  localparam int SPRITE_W = 60;
  localparam int X_MIN = 10;
  localparam int X_MAX = SCREEN_W - SPRITE_W;
  localparam int START_X = 120;
  localparam int WALK_SPEED = 3;
  localparam int RAMP_FRAMES = 2;
  localparam int MIN_SEP = 48;
  typedef enum logic [1:0] {IDLE, WALK_L, WALK_R, HOLD} walk_state_t;
  function automatic logic signed [31:0] smax(input logic signed [31:0] a, input logic signed [31:0] b);
    return a > b ? a : b;
  endfunction
  function automatic logic signed [31:0] smin(input logic signed [31:0] a, input logic signed [31:0] b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/p1_walk_fsm.sv
// p1_walk_fsm: walk state and speed ramp, velocity taken from the state being entered this frame
module p1_walk_fsm
  import game_pkg::*;
#(
  parameter int WALK_SPEED = game_pkg::WALK_SPEED,
  parameter int RAMP_FRAMES = game_pkg::RAMP_FRAMES
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               i_frame_tick,
  input  logic               i_walk_left,
  input  logic               i_walk_right,
  input  logic               i_crouch,
  input  logic               i_knock_active,
  output walk_state_t        o_state,
  output logic signed [31:0] o_velocity
);
  localparam int RW = $clog2(RAMP_FRAMES + 2);
  walk_state_t r_state, w_next;
  logic [RW-1:0] r_ramp, w_ramp_next;
  logic signed [31:0] w_speed;
  logic w_walking;
  // next state: crouch/knockback freeze walking, direction reversal passes through IDLE
  always_comb begin
    w_next = (i_crouch || i_knock_active) ? HOLD
           : (i_walk_left && i_walk_right) ? IDLE
           : (i_walk_left && (r_state == IDLE || r_state == WALK_L)) ? WALK_L
           : (i_walk_right && (r_state == IDLE || r_state == WALK_R)) ? WALK_R
           : IDLE;
    w_walking = (w_next == WALK_L) || (w_next == WALK_R);
    w_ramp_next = (!w_walking || w_next != r_state) ? '0
                : (r_ramp == RW'(RAMP_FRAMES)) ? r_ramp : r_ramp + 1'b1;
    w_speed = (w_ramp_next < RW'(RAMP_FRAMES)) ? 32'sd1 : 32'(WALK_SPEED);
    o_velocity = (w_next == WALK_R) ? w_speed : (w_next == WALK_L) ? -w_speed : '0;
  end
  // state and ramp advance only on the frame strobe
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_ramp <= '0;
    end else if (i_frame_tick) begin
      r_state <= w_next;
      r_ramp <= w_ramp_next;
    end
  end
  assign o_state = r_state;
endmodule

// File: rtl/p1_position_integrator.sv
// p1_position_integrator: per-frame player-1 X integration with pushbox and wall clamping
module p1_position_integrator
  import game_pkg::*;
#(
  parameter int X_MIN = game_pkg::X_MIN,
  parameter int X_MAX = game_pkg::X_MAX,
  parameter int START_X = game_pkg::START_X,
  parameter int WALK_SPEED = game_pkg::WALK_SPEED,
  parameter int RAMP_FRAMES = game_pkg::RAMP_FRAMES,
  parameter int MIN_SEP = game_pkg::MIN_SEP
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               walk_left,
  input  logic               walk_right,
  input  logic               crouch,
  input  logic signed [31:0] knock_motion,
  input  logic               knock_active,
  input  logic signed [31:0] Opp_X,
  output logic signed [31:0] Xpos,
  output logic               RyuLeft,
  output logic               at_left_wall,
  output logic               at_right_wall,
  output walk_state_t        walk_state
);
  logic signed [31:0] r_xpos, w_velocity, w_cand, w_lim_l, w_lim_r, w_push, w_next_x;
  logic r_ryu_left, r_at_l, r_at_r, w_next_rl;
  p1_walk_fsm #(.WALK_SPEED(WALK_SPEED), .RAMP_FRAMES(RAMP_FRAMES)) u_walk (
    .clk(clk),
    .Reset(Reset),
    .i_frame_tick(frame_tick),
    .i_walk_left(walk_left),
    .i_walk_right(walk_right),
    .i_crouch(crouch),
    .i_knock_active(knock_active),
    .o_state(walk_state),
    .o_velocity(w_velocity)
  );
  // candidate move, pushbox only blocks motion toward the opponent, then walls override
  always_comb begin
    w_cand = r_xpos + (knock_active ? knock_motion : w_velocity);
    w_lim_l = Opp_X - 32'(MIN_SEP);
    w_lim_r = Opp_X + 32'(MIN_SEP);
    w_push = r_ryu_left ? ((w_cand > w_lim_l) ? smax(r_xpos, w_lim_l) : w_cand)
                        : ((w_cand < w_lim_r) ? smin(r_xpos, w_lim_r) : w_cand);
    w_next_x = smin(smax(w_push, 32'(X_MIN)), 32'(X_MAX));
    w_next_rl = (w_next_x < Opp_X) ? 1'b1 : (w_next_x > Opp_X) ? 1'b0 : r_ryu_left;
  end
  // position, facing and wall flags commit together on the frame strobe
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_xpos <= 32'(START_X);
      r_ryu_left <= 1'b1;
      r_at_l <= 1'b0;
      r_at_r <= 1'b0;
    end else if (frame_tick) begin
      r_xpos <= w_next_x;
      r_ryu_left <= w_next_rl;
      r_at_l <= w_next_x == 32'(X_MIN);
      r_at_r <= w_next_x == 32'(X_MAX);
    end
  end
  assign Xpos = r_xpos;
  assign RyuLeft = r_ryu_left;
  assign at_left_wall = r_at_l;
  assign at_right_wall = r_at_r;
endmodule

// File: tb/tb_p1_position_integrator.sv
// tb_p1_position_integrator: directed and randomized frames checked against a behavioural model
module tb_p1_position_integrator;
  localparam int XL = 10, XR = 580, START = 120, WS = 3, RAMP = 2, SEP = 48;
  logic clk = 0, Reset = 0, frame_tick = 0, walk_left = 0, walk_right = 0, crouch = 0, knock_active = 0;
  logic signed [31:0] knock_motion = 0, Opp_X = 400, Xpos;
  logic RyuLeft, at_left_wall, at_right_wall;
  logic [1:0] walk_state;
  int n_checks = 0, n_fail = 0;
  int m_x, m_rl, m_st, m_run;
  int exp_w[5] = '{121, 122, 125, 128, 131};
  int exp_p[5] = '{346, 347, 350, 352, 352};

  p1_position_integrator dut (
    .clk(clk), .Reset(Reset), .frame_tick(frame_tick), .walk_left(walk_left),
    .walk_right(walk_right), .crouch(crouch), .knock_motion(knock_motion),
    .knock_active(knock_active), .Opp_X(Opp_X), .Xpos(Xpos), .RyuLeft(RyuLeft),
    .at_left_wall(at_left_wall), .at_right_wall(at_right_wall), .walk_state(walk_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = START; m_rl = 1; m_st = 0; m_run = 0;
  endtask

  // state codes: 0 idle, 1 walking left, 2 walking right, 3 hold
  task automatic model_tick(input bit l, input bit r, input bit c, input bit ka, input int km, input int opp);
    int ns, v, cand;
    if (c || ka) ns = 3;
    else if (l && r) ns = 0;
    else if (l && (m_st == 0 || m_st == 1)) ns = 1;
    else if (r && (m_st == 0 || m_st == 2)) ns = 2;
    else ns = 0;
    m_run = (ns == m_st && (ns == 1 || ns == 2)) ? m_run + 1 : 0;
    v = (ns == 1 || ns == 2) ? ((m_run < RAMP) ? 1 : WS) : 0;
    if (ns == 1) v = -v;
    m_st = ns;
    cand = m_x + (ka ? km : v);
    if (m_rl == 1 && cand > opp - SEP) cand = (m_x > opp - SEP) ? m_x : opp - SEP;
    if (m_rl == 0 && cand < opp + SEP) cand = (m_x < opp + SEP) ? m_x : opp + SEP;
    if (cand < XL) cand = XL;
    if (cand > XR) cand = XR;
    if (cand < opp) m_rl = 1;
    else if (cand > opp) m_rl = 0;
    m_x = cand;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".xpos"}, Xpos, m_x);
    chk({tag, ".ryu_left"}, RyuLeft, m_rl);
    chk({tag, ".at_left"}, at_left_wall, m_x == XL);
    chk({tag, ".at_right"}, at_right_wall, m_x == XR);
    chk({tag, ".state"}, walk_state, m_st);
  endtask

  task automatic tick(input bit l, input bit r, input bit c, input bit ka, input int km, input int opp);
    @(negedge clk);
    walk_left = l; walk_right = r; crouch = c; knock_active = ka; knock_motion = km; Opp_X = opp;
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    model_tick(l, r, c, ka, km, opp);
    check_model("tick");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    Reset = 1;
    model_reset();
    chk("rst.xpos", Xpos, START);
    chk("rst.ryu_left", RyuLeft, 1);
    chk("rst.at_left", at_left_wall, 0);
    chk("rst.at_right", at_right_wall, 0);
    chk("rst.state", walk_state, 0);
    tick(0, 0, 0, 0, 0, 400);
    chk("idle.xpos", Xpos, 120);
    chk("idle.ryu_left", RyuLeft, 1);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 0, 0, 0, 400);
      chk("walk_r.xpos", Xpos, exp_w[i]);
    end
    tick(0, 0, 0, 1, 13 - m_x, 400);
    chk("knock13.xpos", Xpos, 13);
    tick(0, 0, 0, 1, -8, 400);
    chk("knock_wall.xpos", Xpos, 10);
    chk("knock_wall.at_left", at_left_wall, 1);
    tick(0, 0, 0, 1, -8, 400);
    chk("knock_wall2.xpos", Xpos, 10);
    tick(0, 0, 0, 1, 345 - m_x, 400);
    tick(0, 0, 0, 0, 0, 400);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 0, 0, 0, 400);
      chk("push.xpos", Xpos, exp_p[i]);
    end
    chk("push.state", walk_state, 2);
    tick(1, 0, 0, 0, 0, 400);
    chk("reverse.state", walk_state, 0);
    chk("reverse.xpos", Xpos, 352);
    tick(1, 0, 0, 0, 0, 400);
    tick(1, 0, 0, 0, 0, 400);
    tick(1, 0, 0, 0, 0, 400);
    chk("walk_l.xpos", Xpos, 347);
    tick(1, 0, 1, 0, 0, 400);
    chk("crouch.state", walk_state, 3);
    chk("crouch.xpos", Xpos, 347);
    tick(1, 0, 0, 0, 0, 400);
    chk("release.state", walk_state, 0);
    chk("release.xpos", Xpos, 347);
    tick(1, 0, 0, 0, 0, 400);
    chk("ramp_restart.xpos", Xpos, 346);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      walk_right = 1; knock_active = 1; knock_motion = 50; crouch = 0;
      chk("no_tick.xpos", Xpos, m_x);
      chk("no_tick.state", walk_state, m_st);
    end
    tick(0, 0, 0, 1, 192 - m_x, 400);
    tick(0, 0, 0, 0, 0, 400);
    repeat (4) tick(0, 1, 0, 0, 0, 400);
    chk("pre_rst.xpos", Xpos, 200);
    chk("pre_rst.state", walk_state, 2);
    @(negedge clk);
    #2 Reset = 0;
    #1;
    model_reset();
    chk("async_rst.xpos", Xpos, 120);
    chk("async_rst.state", walk_state, 0);
    chk("async_rst.ryu_left", RyuLeft, 1);
    @(negedge clk);
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    check_model("rst_tick");
    Reset = 1;
    tick(0, 0, 0, 0, 0, 100);
    chk("face.ryu_left", RyuLeft, 0);
    tick(0, 0, 0, 1, 1000, 100);
    chk("right_wall.xpos", Xpos, 580);
    chk("right_wall.at_right", at_right_wall, 1);
    tick(0, 0, 0, 0, 0, 580);
    chk("equal_opp.ryu_left", RyuLeft, 0);
    begin
      int opp;
      opp = 400;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 19) == 0) opp = int'($urandom_range(0, 640));
        tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
             $urandom_range(0, 6) == 0, int'($urandom_range(0, 120)) - 60, opp);
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          walk_left = 1'($urandom_range(0, 1)); walk_right = 1'($urandom_range(0, 1));
          knock_active = 1'($urandom_range(0, 1)); knock_motion = int'($urandom_range(0, 40)) - 20;
          chk("gap.xpos", Xpos, m_x);
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
